// File: rtl/csr_row_mac.sv
// csr_row_mac: CSR sparse-row times dense-vector MAC; define CSR_ROW_MAC_SAT_EN for saturating accumulation
module csr_row_mac #(
  parameter int N = 64,
  parameter int DATA_W = 16,
  parameter int ACC_W = 40,
  parameter int ROW_W = 16,
  localparam int COL_W = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              vec_we,
  input  logic [COL_W-1:0]  vec_addr,
  input  logic [DATA_W-1:0] vec_wdata,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_val,
  input  logic [COL_W:0]    in_col,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_data,
  output logic [ROW_W-1:0]  out_row,
  output logic              err_col
);
  typedef enum logic [1:0] {ACCUM, DRAIN, OUT} stateT;
  stateT state, stateNext;
  logic drainCnt, s1Valid, accept, colOk, errCol;
  logic signed [DATA_W-1:0] vecRam [N];
  logic signed [DATA_W-1:0] rdData, s1Val;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0] acc, accNext, prodExt, sum, outData;
  logic [ROW_W-1:0] rowCnt;
`ifdef CSR_ROW_MAC_SAT_EN
  logic ovf, satHold;
`endif
  assign accept = in_valid && in_ready;
  assign colOk = in_col < (COL_W+1)'(N);
  assign in_ready = rst_n && state == ACCUM;
  assign out_valid = state == OUT;
  assign out_data = outData;
  assign out_row = rowCnt;
  assign err_col = errCol;
  // vector RAM write port, contents survive reset
  always_ff @(posedge clk)
    if (vec_we) vecRam[vec_addr] <= vec_wdata;
  // next state: last beat starts a two-cycle drain, result waits in OUT for out_ready
  always_comb begin
    stateNext = state;
    stateNext = (state == ACCUM && accept && in_last) ? DRAIN :
                (state == DRAIN && drainCnt) ? OUT :
                (state == OUT && out_ready) ? ACCUM : state;
  end
  // full-width signed product, sign-extended and added to the accumulator
  always_comb begin
    prod = s1Val * rdData;
    prodExt = prod;
    sum = acc + prodExt;
`ifdef CSR_ROW_MAC_SAT_EN
    ovf = (acc[ACC_W-1] == prodExt[ACC_W-1]) && (sum[ACC_W-1] != acc[ACC_W-1]);
    accNext = satHold ? acc :
              ovf ? (acc[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}}) : sum;
`else
    accNext = sum;
`endif
  end
  // state, read pipeline, accumulator and result registers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= ACCUM;
      drainCnt <= 1'b0;
      s1Valid <= 1'b0;
      s1Val <= '0;
      rdData <= '0;
      acc <= '0;
      outData <= '0;
      rowCnt <= '0;
      errCol <= 1'b0;
`ifdef CSR_ROW_MAC_SAT_EN
      satHold <= 1'b0;
`endif
    end else begin
      state <= stateNext;
      drainCnt <= state == DRAIN ? ~drainCnt : 1'b0;
      s1Valid <= accept;
      if (accept) begin
        s1Val <= in_val;
        rdData <= colOk ? vecRam[in_col[COL_W-1:0]] : '0;
      end
      if (accept && !colOk) errCol <= 1'b1;
      if (state == OUT && out_ready) begin
        acc <= '0;
        rowCnt <= rowCnt + 1'b1;
`ifdef CSR_ROW_MAC_SAT_EN
        satHold <= 1'b0;
`endif
      end else if (s1Valid) begin
        acc <= accNext;
`ifdef CSR_ROW_MAC_SAT_EN
        if (ovf) satHold <= 1'b1;
`endif
      end
      if (state == DRAIN && drainCnt) outData <= acc;
    end
endmodule

// File: tb/tb_csr_row_mac.sv
// tb_csr_row_mac: directed table-driven bench for csr_row_mac
module tb_csr_row_mac;
  localparam int N = 64;
  localparam int DW = 16;
  localparam int AW = 32;
  localparam int RW = 16;
  localparam int CW = $clog2(N);
  typedef struct {
    int val;
    int col;
    bit last;
    longint expData;
    int expRow;
  } beatT;
  logic clk = 0, rst_n = 0;
  logic vec_we = 0;
  logic [CW-1:0] vec_addr = '0;
  logic [DW-1:0] vec_wdata = '0;
  logic in_valid = 0, in_ready, in_last = 0;
  logic [DW-1:0] in_val = '0;
  logic [CW:0] in_col = '0;
  logic out_valid, out_ready = 0, err_col;
  logic [AW-1:0] out_data;
  logic [RW-1:0] out_row;
  int passed = 0, total = 0;
  beatT tbl [0:6];

  csr_row_mac #(.N(N), .DATA_W(DW), .ACC_W(AW), .ROW_W(RW)) dut (
    .clk(clk), .rst_n(rst_n), .vec_we(vec_we), .vec_addr(vec_addr), .vec_wdata(vec_wdata),
    .in_valid(in_valid), .in_ready(in_ready), .in_val(in_val), .in_col(in_col), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_row(out_row), .err_col(err_col)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic writeVec(input int a, input int v);
    @(negedge clk);
    vec_we = 1; vec_addr = CW'(a); vec_wdata = DW'(v);
  endtask

  task automatic sendBeat(input int v, input int c, input bit l);
    int n = 0;
    @(negedge clk);
    in_valid = 1; in_val = DW'(v); in_col = (CW+1)'(c); in_last = l;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n == 20) chk("in_ready wait", 0, 1);
    @(posedge clk);
  endtask

  task automatic getResult(input string nm, input longint ed, input int er, input int hold);
    int n = 1;
    int bad = 0;
    @(negedge clk);
    in_valid = 0; in_last = 0; vec_we = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({nm, " latency"}, n, 3);
    chk({nm, " data"}, $signed(out_data), ed);
    chk({nm, " row"}, out_row, er);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (!out_valid || $signed(out_data) != ed || out_row != RW'(er) || in_ready) bad++;
    end
    if (hold > 0) chk({nm, " hold stable"}, bad, 0);
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    chk({nm, " ack"}, out_valid, 0);
  endtask

  initial begin
    tbl[0] = '{5, 0, 0, 0, 0};
    tbl[1] = '{6, 2, 0, 0, 0};
    tbl[2] = '{7, 3, 1, 51, 0};
    tbl[3] = '{0, 0, 1, 0, 1};
    tbl[4] = '{-2, 1, 1, -4, 2};
    tbl[5] = '{-3, 5, 0, 0, 0};
    tbl[6] = '{4, 63, 1, 409, 3};
    repeat (3) @(negedge clk);
    chk("reset in_ready", in_ready, 0);
    chk("reset out_valid", out_valid, 0);
    chk("reset out_row", out_row, 0);
    chk("reset out_data", out_data, 0);
    chk("reset err_col", err_col, 0);
    rst_n = 1;
    #1 chk("release in_ready", in_ready, 1);
    writeVec(0, 1);
    writeVec(1, 2);
    writeVec(2, 3);
    writeVec(3, 4);
    writeVec(5, -3);
    writeVec(63, 100);
    writeVec(10, 32767);
    @(negedge clk);
    vec_we = 0;
    for (int i = 0; i <= 6; i++) begin
      sendBeat(tbl[i].val, tbl[i].col, tbl[i].last);
      if (tbl[i].last) getResult($sformatf("row%0d", tbl[i].expRow), tbl[i].expData, tbl[i].expRow, 0);
    end
    sendBeat(-32768, 3, 0);
    sendBeat(100, 1, 1);
    getResult("neg row4", -130872, 4, 0);
    sendBeat(1, 3, 1);
    getResult("hold row5", 4, 5, 10);
    sendBeat(2, 0, 0);
    @(negedge clk);
    in_valid = 0;
    repeat (3) @(negedge clk);
    sendBeat(3, 1, 1);
    getResult("gap row6", 8, 6, 0);
    chk("err_col before bad col", err_col, 0);
    sendBeat(9, N, 0);
    sendBeat(1, 0, 1);
    getResult("badcol row7", 1, 7, 0);
    chk("err_col after bad col", err_col, 1);
    @(negedge clk);
    in_valid = 1; in_val = 1; in_col = 2; in_last = 1;
    vec_we = 1; vec_addr = 2; vec_wdata = 50;
    @(posedge clk);
    getResult("raw old row8", 3, 8, 0);
    sendBeat(1, 2, 1);
    getResult("raw new row9", 50, 9, 0);
    sendBeat(32767, 10, 0);
    sendBeat(32767, 10, 0);
    sendBeat(32767, 10, 1);
`ifdef CSR_ROW_MAC_SAT_EN
    getResult("sat row10", 2147483647, 10, 0);
`else
    getResult("wrap row10", -1073938429, 10, 0);
`endif
    chk("err_col sticky", err_col, 1);
    sendBeat(5, 0, 0);
    sendBeat(6, 2, 0);
    @(negedge clk);
    in_valid = 0; in_last = 0;
    rst_n = 0;
    #1;
    chk("midrow rst out_valid", out_valid, 0);
    chk("midrow rst out_row", out_row, 0);
    chk("midrow rst in_ready", in_ready, 0);
    chk("midrow rst err_col", err_col, 0);
    @(negedge clk);
    rst_n = 1;
    #1 chk("midrow release in_ready", in_ready, 1);
    sendBeat(7, 3, 1);
    getResult("post reset row0", 28, 0, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/csr_row_mac.md
CSR_ROW_MAC -- requirements
Module: csr_row_mac

Interface
REQ-001 SHALL have parameter N, default 64: dense input-vector length, also the vector RAM depth.
REQ-002 SHALL have parameter DATA_W, default 16: signed two's-complement width of matrix values and vector entries.
REQ-003 SHALL have parameter ACC_W, default 40: signed accumulator and result width, at least 2*DATA_W.
REQ-004 SHALL have parameter ROW_W, default 16: width of the row counter.
REQ-005 SHALL derive COL_W = $clog2(N) for column and vector addresses.
REQ-006 clk  in  1  sole clock; all state updates on the rising edge.
REQ-007 rst_n  in  1  asynchronous active-low reset.
REQ-008 vec_we / vec_addr / vec_wdata  in  1 / COL_W / DATA_W  vector RAM write port.
REQ-009 in_valid / in_ready  in / out  1 / 1  nonzero-beat handshake.
REQ-010 in_val / in_col / in_last  in  DATA_W / COL_W+1 / 1  nonzero value, column index, last beat of the row.
REQ-011 out_valid / out_ready  out / in  1 / 1  result handshake.
REQ-012 out_data / out_row  out  ACC_W / ROW_W  row dot-product and row index.
REQ-013 err_col  out  1  sticky out-of-range-column flag.

Function
REQ-014 SHALL compute, per row, the sum of in_val*x[in_col] over all beats up to and including the in_last beat.
REQ-015 SHALL use an FSM with states ACCUM, DRAIN and OUT; reset state is ACCUM.
REQ-016 A beat SHALL be accepted on a cycle with in_valid && in_ready; in_ready SHALL be 1 only in ACCUM.
REQ-017 Pipeline: vector RAM read registered at t+1; product added to the accumulator at t+2, for a beat accepted at cycle t.
REQ-018 Accepting an in_last beat SHALL move ACCUM->DRAIN; DRAIN SHALL last exactly 2 cycles, then go to OUT.
REQ-019 out_valid SHALL assert exactly 3 cycles after in_last acceptance and hold, with stable out_data and out_row, until out_ready.
REQ-020 OUT->ACCUM on out_valid && out_ready; the accumulator SHALL clear and out_row SHALL increment in the same cycle.
REQ-021 out_row SHALL wrap from 2^ROW_W-1 to 0.
REQ-022 Products SHALL be full 2*DATA_W signed, sign-extended to ACC_W before accumulation.
REQ-023 A beat with in_col >= N SHALL contribute zero and set err_col, which stays set until reset.
REQ-024 Empty rows SHALL be sent as one beat with in_val=0 and in_last=1, yielding result 0.
REQ-025 Vector writes SHALL be accepted in any state; a read and write to the same address in one cycle SHALL return old data.
REQ-026 Gaps in in_valid SHALL stall without altering the accumulator; back-to-back beats SHALL sustain one per cycle.

Reset
REQ-027 rst_n low SHALL immediately clear state, accumulator, pipeline valids, out_valid, out_data, out_row and err_col, and force in_ready to 0 while rst_n is low.
REQ-028 Vector RAM contents SHALL NOT be reset.
REQ-029 Reset mid-row or while in OUT SHALL discard the partial or pending result; in_ready SHALL be 1 on the first cycle after release.

Configuration
REQ-030 Macro CSR_ROW_MAC_SAT_EN defined: accumulation SHALL saturate to the signed ACC_W maximum or minimum on overflow, and the result SHALL stay clamped for the rest of the row.
REQ-031 Macro CSR_ROW_MAC_SAT_EN undefined: accumulation SHALL wrap modulo 2^ACC_W.

Verification
REQ-032 x[0..3]={1,2,3,4}; beats (5,col0),(6,col2),(7,col3,last) -> out_data=5+18+28=51, out_row=0, out_valid 3 cycles after the last beat.
REQ-033 Empty-row beat (0,col0,last), then row (-2,col1,last) -> results 0 (row 0), then -4 (row 1).
REQ-034 Hold out_ready=0 for 10 cycles -> out_valid and out_data stable, in_ready=0 throughout; release -> next row accepted.
REQ-035 in_col=N -> contribution 0 and err_col=1 until rst_n pulse.
REQ-036 DATA_W=16, ACC_W=32; 3 beats of 32767*32767 -> wrapped sum without the macro, 2147483647 with CSR_ROW_MAC_SAT_EN.
REQ-037 Assert rst_n low after 2 beats of a row -> out_valid=0, out_row=0; the next full row returns only its own sum.
